rank_axil_regbank: RTL and testbench
====================================

# rank_axil_regbank

Parametrised AXI4-Lite slave register bank for RankIP control/status. Generalises the fixed four-register S00_AXI slave to NUM_REGS registers of DATA_WIDTH bits. Adds byte strobes, per-register read-only mapping to core status inputs, SLVERR on out-of-range addresses, and per-register write pulses to the RankIP core. Sits between the AXI interconnect (or master VIP in the BFM design) and the RankIP datapath.

## Interface
- DATA_WIDTH, 32: register and bus width; 32 or 64.
- NUM_REGS, 4: number of registers; 1..64.
- ADDR_WIDTH, 6: AXI address width; must be at least clog2(NUM_REGS)+clog2(DATA_WIDTH/8).
- RO_MASK, 0: NUM_REGS-bit vector; bit i set makes register i read-only (sourced from reg_d).

- ACLK  in  1  clock.
- ARESETN  in  1  synchronous, active-low reset.
- AWADDR  in  ADDR_WIDTH; AWPROT  in  3 (ignored); AWVALID  in  1; AWREADY  out  1.
- WDATA  in  DATA_WIDTH; WSTRB  in  DATA_WIDTH/8; WVALID  in  1; WREADY  out  1.
- BRESP  out  2; BVALID  out  1; BREADY  in  1.
- ARADDR  in  ADDR_WIDTH; ARPROT  in  3 (ignored); ARVALID  in  1; ARREADY  out  1.
- RDATA  out  DATA_WIDTH; RRESP  out  2; RVALID  out  1; RREADY  in  1.
- reg_q  out  NUM_REGS*DATA_WIDTH: current RW register contents; register i is at [i*DATA_WIDTH +: DATA_WIDTH].
- reg_d  in  NUM_REGS*DATA_WIDTH: status values for RO registers; lanes of RW registers are ignored.
- wr_pulse  out  NUM_REGS: one-cycle pulse on each accepted write to RW register i.

## Operation
- Index = ADDR[ADDR_WIDTH-1 : clog2(DATA_WIDTH/8)]. Low byte-offset bits are ignored. Index >= NUM_REGS is out of range.
- Write FSM has two states, W_IDLE and W_RESP.
  - In W_IDLE, AW and W are captured independently. AWREADY is high until AW is captured; WREADY is high until W is captured. Either may arrive first, with any gap.
  - When both are held (including the same cycle), the FSM moves to W_RESP.
- On entry to W_RESP:
  - In range and RW: each byte lane with WSTRB set is updated. BRESP=OKAY. wr_pulse[i]=1 for one cycle.
  - In range and RO: no update, no pulse, BRESP=OKAY (write silently ignored).
  - Out of range: no update, no pulse, BRESP=SLVERR (2'b10).
- BVALID is held with BRESP stable until BREADY. It then drops and the FSM returns to W_IDLE with AW/W capture cleared.
- Read FSM has two states, R_IDLE and R_DATA.
  - ARREADY=1 only in R_IDLE.
  - On the AR handshake, RDATA and RRESP are latched and the FSM moves to R_DATA.
  - RW register: RDATA = reg_q value at the handshake cycle (pre-write if a write commits that same edge).
  - RO register: RDATA = reg_d sampled at the handshake cycle.
  - Out of range: RDATA=0, RRESP=SLVERR.
  - RVALID is held with data stable until RREADY, then the FSM returns to R_IDLE.
- Read and write channels are fully independent. No ordering between them is enforced.

## Timing
- Reset (ARESETN low at a rising edge):
  - All registers, reg_q and wr_pulse go to 0.
  - BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0.
  - AWREADY=WREADY=ARREADY=0 while reset is asserted. They rise in the first cycle with ARESETN high.
- Reset mid-transaction abandons it: captured AW/W are discarded, and no B or R is issued.
- Write latency: last of AW/W handshakes at cycle T. Then reg_q updated, wr_pulse and BVALID high at T+1.
- Read latency: AR handshake at T, RVALID at T+1.
- Throughput with BREADY/RREADY tied high: one write per 2 cycles and one read per 2 cycles, concurrently.
- AWREADY and WREADY are low in W_RESP. A new AW/W may be accepted in the cycle after the B handshake.
- wr_pulse is exactly one cycle per accepted write, independent of BREADY stall length.

## Test plan
- NUM_REGS=4, DATA_WIDTH=32: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back. Required: 0x1..0x4 with OKAY; reg_q={4,3,2,1}; wr_pulse seen once per register.
- Reg0=0xAABBCCDD, then write 0x11223344 with WSTRB=4'b0101. Required: read 0xAA22CC44.
- WVALID 3 cycles before AWVALID, then the reverse order. Required: each handshakes once; BVALID one cycle after the later handshake; correct data stored.
- Write/read address 0x10 with NUM_REGS=4. Required: BRESP=SLVERR, RRESP=SLVERR, RDATA=0, reg_q unchanged.
- RO_MASK=4'b0010, reg_d lane1=0xCAFE0001: write 0x5 to 0x4, then read 0x4. Required: OKAY with no wr_pulse; read returns 0xCAFE0001.
- Hold BREADY low 5 cycles. Required: BVALID/BRESP stable, AWREADY low throughout. Separately, assert reset while BVALID=1. Required: BVALID=0 the next cycle and no B response after reset.

Source files
------------

// File: rtl/rank_axil_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS x DATA_WIDTH control/status registers for the RankIP core.
// Latency: write commits, wr_pulse and BVALID one cycle after the later of AW/W; RVALID one cycle after AR.
// Backpressure: AW/W/AR ready drop while a response is pending; B and R are held stable until BREADY/RREADY.
//
// Ports:
//   ACLK, ARESETN             clock, synchronous active-low reset
//   AW*/W*/B*                 AXI4-Lite write address, write data and write response channels
//   AR*/R*                    AXI4-Lite read address and read data channels
//   reg_q                     RW register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_d                     status inputs returned for registers flagged in RO_MASK
//   wr_pulse                  one-cycle strobe per accepted write to RW register i

module rank_axil_regbank #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 4,
    parameter int                  ADDR_WIDTH = 6,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,

    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           AWVALID,
    output logic                           AWREADY,

    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,

    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,

    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,

    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,

    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_d,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int         STRB_W      = DATA_WIDTH / 8;
    localparam int         BYTE_BITS   = $clog2(STRB_W);
    localparam int         IDX_W       = ADDR_WIDTH - BYTE_BITS;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    wstate_t                r_wstate;
    wstate_t                w_wstate_nxt;
    rstate_t                r_rstate;
    rstate_t                w_rstate_nxt;

    logic                   r_aw_held;
    logic [IDX_W-1:0]       r_aw_idx;
    logic                   r_w_held;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [STRB_W-1:0]      r_wstrb;
    logic [1:0]             r_bresp;
    logic [NUM_REGS-1:0]    r_wr_pulse;
    logic [DATA_WIDTH-1:0]  r_regs [NUM_REGS];

    logic [DATA_WIDTH-1:0]  r_rdata;
    logic [1:0]             r_rresp;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_commit;
    logic [IDX_W-1:0]       w_cur_aw_idx;
    logic [DATA_WIDTH-1:0]  w_cur_wdata;
    logic [STRB_W-1:0]      w_cur_wstrb;
    logic                   w_wr_inrange;

    // Readies are gated by ARESETN so they are low throughout reset and
    // come up in the very first cycle the reset is released.
    assign AWREADY = ARESETN && (r_wstate == W_IDLE) && !r_aw_held;
    assign WREADY  = ARESETN && (r_wstate == W_IDLE) && !r_w_held;

    assign w_aw_hs = AWVALID && AWREADY;
    assign w_w_hs  = WVALID && WREADY;

    // A beat arriving this cycle is used directly, so AW and W landing
    // together (or the second of them landing) commits on the same edge.
    assign w_cur_aw_idx = r_aw_held ? r_aw_idx : AWADDR[ADDR_WIDTH-1:BYTE_BITS];
    assign w_cur_wdata  = r_w_held  ? r_wdata  : WDATA;
    assign w_cur_wstrb  = r_w_held  ? r_wstrb  : WSTRB;

    assign w_commit     = (r_wstate == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_inrange = (32'(w_cur_aw_idx) < NUM_REGS);

    always_comb begin
        w_wstate_nxt = r_wstate;
        if (r_wstate == W_IDLE) begin
            if (w_commit) begin
                w_wstate_nxt = W_RESP;
            end
        end else begin
            if (BREADY) begin
                w_wstate_nxt = W_IDLE;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_aw_held  <= 1'b0;
            r_aw_idx   <= '0;
            r_w_held   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_pulse <= '0;

            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= AWADDR[ADDR_WIDTH-1:BYTE_BITS];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= WDATA;
                r_wstrb  <= WSTRB;
            end

            // Commit clears the captures; this later assignment overrides
            // the capture above when the final beat arrives this cycle.
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bresp   <= w_wr_inrange ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    // Read-only registers swallow the write with an OKAY.
                    if ((w_cur_aw_idx == IDX_W'(i)) && !RO_MASK[i]) begin
                        r_wr_pulse[i] <= 1'b1;
                        for (int b = 0; b < STRB_W; b++) begin
                            if (w_cur_wstrb[b]) begin
                                r_regs[i][8*b +: 8] <= w_cur_wdata[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    assign BVALID   = (r_wstate == W_RESP);
    assign BRESP    = r_bresp;
    assign wr_pulse = r_wr_pulse;

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic                   w_ar_hs;
    logic [IDX_W-1:0]       w_ar_idx;
    logic                   w_rd_inrange;
    logic [DATA_WIDTH-1:0]  w_rd_val;

    assign ARREADY      = ARESETN && (r_rstate == R_IDLE);
    assign w_ar_hs      = ARVALID && ARREADY;
    assign w_ar_idx     = ARADDR[ADDR_WIDTH-1:BYTE_BITS];
    assign w_rd_inrange = (32'(w_ar_idx) < NUM_REGS);

    // RW registers return their stored value as of this cycle, so a write
    // committing on the same edge is not visible to this read.
    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_idx == IDX_W'(i)) begin
                w_rd_val = RO_MASK[i] ? reg_d[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        if (r_rstate == R_IDLE) begin
            if (w_ar_hs) begin
                w_rstate_nxt = R_DATA;
            end
        end else begin
            if (RREADY) begin
                w_rstate_nxt = R_IDLE;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_inrange ? w_rd_val : '0;
            r_rresp <= w_rd_inrange ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign RVALID = (r_rstate == R_DATA);
    assign RDATA  = r_rdata;
    assign RRESP  = r_rresp;

    // Protection bits, byte-offset address bits and the reg_d lanes of RW
    // registers carry no meaning for this block.
    logic w_unused_ok;
    assign w_unused_ok = ^{AWPROT, ARPROT, AWADDR[BYTE_BITS-1:0], ARADDR[BYTE_BITS-1:0], reg_d};

endmodule

// File: tb/tb_rank_axil_regbank.sv
module tb_rank_axil_regbank;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [5:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         bready;
    logic [5:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         rready;
    logic [127:0] reg_d;

    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [127:0] reg_q;
    logic [3:0]   wr_pulse;

    logic         ro_awready, ro_wready, ro_bvalid, ro_arready, ro_rvalid;
    logic [1:0]   ro_bresp, ro_rresp;
    logic [31:0]  ro_rdata;
    logic [127:0] ro_reg_q;
    logic [3:0]   ro_wr_pulse;

    rank_axil_regbank #(.DATA_WIDTH(32), .NUM_REGS(4), .ADDR_WIDTH(6), .RO_MASK(4'b0000)) dut (
        .ACLK(clk), .ARESETN(rst_n),
        .AWADDR(awaddr), .AWPROT(awprot), .AWVALID(awvalid), .AWREADY(awready),
        .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
        .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
        .ARADDR(araddr), .ARPROT(arprot), .ARVALID(arvalid), .ARREADY(arready),
        .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready),
        .reg_q(reg_q), .reg_d(reg_d), .wr_pulse(wr_pulse)
    );

    rank_axil_regbank #(.DATA_WIDTH(32), .NUM_REGS(4), .ADDR_WIDTH(6), .RO_MASK(4'b0010)) dut_ro (
        .ACLK(clk), .ARESETN(rst_n),
        .AWADDR(awaddr), .AWPROT(awprot), .AWVALID(awvalid), .AWREADY(ro_awready),
        .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(ro_wready),
        .BRESP(ro_bresp), .BVALID(ro_bvalid), .BREADY(bready),
        .ARADDR(araddr), .ARPROT(arprot), .ARVALID(arvalid), .ARREADY(ro_arready),
        .RDATA(ro_rdata), .RRESP(ro_rresp), .RVALID(ro_rvalid), .RREADY(rready),
        .reg_q(ro_reg_q), .reg_d(reg_d), .wr_pulse(ro_wr_pulse)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int aw_hs_cnt, w_hs_cnt, ar_hs_cnt;
    int pulse_cnt [4];
    int ro_pulse_cnt [4];

    // Inputs only change 1 time unit after a rising edge, so the values seen
    // at the falling edge are the ones the next rising edge will act on.
    always @(negedge clk) begin
        if (awvalid && awready) aw_hs_cnt++;
        if (wvalid && wready)   w_hs_cnt++;
        if (arvalid && arready) ar_hs_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (wr_pulse[i])    pulse_cnt[i]++;
            if (ro_wr_pulse[i]) ro_pulse_cnt[i]++;
        end
    end

    task automatic clear_counts();
        aw_hs_cnt = 0; w_hs_cnt = 0; ar_hs_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            pulse_cnt[i] = 0; ro_pulse_cnt[i] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_start(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_done = 0;
        bit w_done  = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
            bit aw_hs, w_hs;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
        end
        n_checks++;
        if (!(aw_done && w_done)) begin
            n_fail++;
            $display("FAIL write_handshake addr=%h got aw=%0b w=%0b exp both 1", addr, aw_done, w_done);
            awvalid = 1'b0; wvalid = 1'b0;
        end
    endtask

    task automatic write_finish(output logic [1:0] resp, output logic [1:0] ro_resp);
        int c = 0;
        n_checks++;
        if (bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL b_latency got bvalid=%b exp 1", bvalid);
        end
        while (bvalid !== 1'b1 && c < 20) begin tick(); c++; end
        resp = bresp; ro_resp = ro_bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [1:0] ro_resp);
        write_start(addr, data, strb);
        write_finish(resp, ro_resp);
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output logic [31:0] ro_data, output logic [1:0] ro_resp);
        bit done = 0;
        araddr = addr; arvalid = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            bit hs;
            hs = arvalid && arready;
            tick();
            if (hs) begin arvalid = 1'b0; done = 1; end
        end
        n_checks++;
        if (!done || rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL read_latency addr=%h got ar_done=%0b rvalid=%b exp 1 1", addr, done, rvalid);
            arvalid = 1'b0;
        end
        data = rdata; resp = rresp; ro_data = ro_rdata; ro_resp = ro_rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; awprot = '0; arprot = '0; reg_d = '0;
        repeat (3) tick();
        n_checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready got=%b exp=000", {awready, wready, arready});
        end
        n_checks++;
        if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin
            n_fail++; $display("FAIL reset_valid got=%b exp=000000", {bvalid, rvalid, bresp, rresp});
        end
        n_checks++;
        if (reg_q !== 128'h0 || wr_pulse !== 4'h0 || rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_regs got reg_q=%h pulse=%h rdata=%h exp 0", reg_q, wr_pulse, rdata);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_fail++; $display("FAIL ready_after_reset got=%b exp=111", {awready, wready, arready});
        end
        tick();
    endtask

    task automatic test_basic();
        logic [1:0] r, rr;
        logic [31:0] d, rd;
        clear_counts();
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(4*i), 32'(i + 1), 4'hF, r, rr);
            n_checks++;
            if (r !== 2'b00) begin n_fail++; $display("FAIL basic_bresp reg%0d got=%b exp=00", i, r); end
        end
        n_checks++;
        if (reg_q !== 128'h00000004_00000003_00000002_00000001) begin
            n_fail++; $display("FAIL basic_reg_q got=%h exp=00000004000000030000000200000001", reg_q);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (pulse_cnt[i] != 1) begin n_fail++; $display("FAIL basic_pulse reg%0d got=%0d exp=1", i, pulse_cnt[i]); end
            axi_read(6'(4*i), d, r, rd, rr);
            n_checks++;
            if (d !== 32'(i + 1) || r !== 2'b00) begin
                n_fail++; $display("FAIL basic_read reg%0d got=%h/%b exp=%h/00", i, d, r, 32'(i + 1));
            end
        end
    endtask

    task automatic test_strobe();
        logic [1:0] r, rr;
        logic [31:0] d, rd;
        axi_write(6'h00, 32'hAABBCCDD, 4'hF, r, rr);
        axi_write(6'h00, 32'h11223344, 4'b0101, r, rr);
        axi_read(6'h00, d, r, rd, rr);
        n_checks++;
        if (d !== 32'hAA22CC44) begin n_fail++; $display("FAIL strobe_read got=%h exp=aa22cc44", d); end
    endtask

    task automatic test_order();
        logic [1:0] r, rr;
        logic [31:0] d, rd;
        // W leads AW by three cycles.
        clear_counts();
        wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (bvalid !== 1'b0 || wready !== 1'b0) begin
            n_fail++; $display("FAIL order_w_wait got bvalid=%b wready=%b exp 0 0", bvalid, wready);
        end
        awaddr = 6'h08; awvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        write_finish(r, rr);
        n_checks++;
        if (aw_hs_cnt != 1 || w_hs_cnt != 1) begin
            n_fail++; $display("FAIL order_w_first_hs got aw=%0d w=%0d exp 1 1", aw_hs_cnt, w_hs_cnt);
        end
        // AW leads W by three cycles.
        clear_counts();
        awaddr = 6'h0C; awvalid = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (bvalid !== 1'b0 || awready !== 1'b0) begin
            n_fail++; $display("FAIL order_aw_wait got bvalid=%b awready=%b exp 0 0", bvalid, awready);
        end
        wdata = 32'h66; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        write_finish(r, rr);
        n_checks++;
        if (aw_hs_cnt != 1 || w_hs_cnt != 1) begin
            n_fail++; $display("FAIL order_aw_first_hs got aw=%0d w=%0d exp 1 1", aw_hs_cnt, w_hs_cnt);
        end
        axi_read(6'h08, d, r, rd, rr);
        n_checks++;
        if (d !== 32'h55) begin n_fail++; $display("FAIL order_data8 got=%h exp=00000055", d); end
        axi_read(6'h0C, d, r, rd, rr);
        n_checks++;
        if (d !== 32'h66) begin n_fail++; $display("FAIL order_dataC got=%h exp=00000066", d); end
    endtask

    task automatic test_oor();
        logic [1:0] r, rr;
        logic [31:0] d, rd;
        clear_counts();
        axi_write(6'h10, 32'hDEADBEEF, 4'hF, r, rr);
        n_checks++;
        if (r !== 2'b10) begin n_fail++; $display("FAIL oor_bresp got=%b exp=10", r); end
        n_checks++;
        if (reg_q !== 128'h00000066_00000055_00000002_AA22CC44) begin
            n_fail++; $display("FAIL oor_reg_q got=%h exp=000000660000005500000002aa22cc44", reg_q);
        end
        n_checks++;
        if (pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] != 0) begin
            n_fail++; $display("FAIL oor_pulse got=%0d exp=0", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]);
        end
        axi_read(6'h10, d, r, rd, rr);
        n_checks++;
        if (r !== 2'b10 || d !== 32'h0) begin n_fail++; $display("FAIL oor_read got=%h/%b exp=00000000/10", d, r); end
    endtask

    task automatic test_ro();
        logic [1:0] r, rr;
        logic [31:0] d, rd;
        reg_d = 128'h00000000_00000000_CAFE0001_00000000;
        clear_counts();
        axi_write(6'h04, 32'h5, 4'hF, r, rr);
        n_checks++;
        if (rr !== 2'b00) begin n_fail++; $display("FAIL ro_bresp got=%b exp=00", rr); end
        n_checks++;
        if (ro_pulse_cnt[1] != 0 || ro_reg_q[63:32] !== 32'h0) begin
            n_fail++; $display("FAIL ro_no_update got pulses=%0d lane=%h exp 0 0", ro_pulse_cnt[1], ro_reg_q[63:32]);
        end
        axi_read(6'h04, d, r, rd, rr);
        n_checks++;
        if (rd !== 32'hCAFE0001 || rr !== 2'b00) begin
            n_fail++; $display("FAIL ro_read got=%h/%b exp=cafe0001/00", rd, rr);
        end
        n_checks++;
        if (d !== 32'h5) begin n_fail++; $display("FAIL rw_ignores_reg_d got=%h exp=00000005", d); end
    endtask

    task automatic test_bstall();
        logic [1:0] r, rr;
        clear_counts();
        write_start(6'h14, 32'h99, 4'hF);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b10 || awready !== 1'b0 || wready !== 1'b0) begin
                n_fail++;
                $display("FAIL bstall_cycle%0d got bvalid=%b bresp=%b awready=%b wready=%b exp 1 10 0 0",
                         c, bvalid, bresp, awready, wready);
            end
            tick();
        end
        write_finish(r, rr);
        n_checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            n_fail++; $display("FAIL bstall_release got bvalid=%b awready=%b exp 0 1", bvalid, awready);
        end
        write_start(6'h0C, 32'h99, 4'hF);
        repeat (5) tick();
        write_finish(r, rr);
        n_checks++;
        if (pulse_cnt[3] != 1) begin n_fail++; $display("FAIL bstall_pulse got=%0d exp=1", pulse_cnt[3]); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] r, rr;
        logic [31:0] d, rd;
        clear_counts();
        awaddr = 6'h04; wdata = 32'hA5; wstrb = 4'hF; araddr = 6'h04;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        repeat (8) tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        n_checks++;
        if (aw_hs_cnt != 4 || w_hs_cnt != 4 || ar_hs_cnt != 4) begin
            n_fail++; $display("FAIL b2b_rate got aw=%0d w=%0d ar=%0d exp 4 4 4", aw_hs_cnt, w_hs_cnt, ar_hs_cnt);
        end
        axi_read(6'h04, d, r, rd, rr);
        n_checks++;
        if (d !== 32'hA5) begin n_fail++; $display("FAIL b2b_data got=%h exp=000000a5", d); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] r, rr;
        logic [31:0] d, rd;
        write_start(6'h00, 32'h1234, 4'hF);
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (bvalid !== 1'b0 || reg_q !== 128'h0) begin
            n_fail++; $display("FAIL rst_mid_b got bvalid=%b reg_q=%h exp 0 0", bvalid, reg_q);
        end
        rst_n = 1'b1;
        bready = 1'b1;
        repeat (3) tick();
        bready = 1'b0;
        n_checks++;
        if (bvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_b got=%b exp=0", bvalid); end
        // A W captured before reset must not pair with an AW after it.
        wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        awaddr = 6'h00; awvalid = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (bvalid !== 1'b0) begin n_fail++; $display("FAIL rst_w_discard got bvalid=%b exp=0", bvalid); end
        wdata = 32'h88; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        write_finish(r, rr);
        axi_read(6'h00, d, r, rd, rr);
        n_checks++;
        if (d !== 32'h88) begin n_fail++; $display("FAIL rst_w_data got=%h exp=00000088", d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_order();
        test_oor();
        test_ro();
        test_bstall();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
